// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract sequencer built around one 1-bit full-adder cell.
//   Operands are captured on an accepted start and fed to the cell LSB first,
//   one bit per clock, through a carry flip-flop. After WIDTH bit-cycles the
//   result and its flags are published together and done pulses for one cycle.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, sampled only in IDLE
//   sub      0 = A+B, 1 = A-B (captured with start)
//   a_in     operand A (captured on the accepting edge)
//   b_in     operand B (captured on the accepting edge)
//   busy     high whenever state != IDLE
//   done     one-cycle pulse; result outputs valid from this cycle on
//   sum      registered result
//   cout     final carry out (subtract: 1 = no borrow)
//   ovf      signed overflow
//   zero     sum == 0
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last completed result
// RUN   | one operand bit per clock through the adder cell
// DONE  | result just published; done pulses, then back to IDLE

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // The single full-adder cell.
  assign cell_s = sh_a[0] ^ sh_b[0] ^ carry;
  assign cell_c = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

  assign res_next = {cell_s, sh_r[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      sh_r  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is A + ~B + 1: invert B here, the +1 enters as carry-in.
            sh_a  <= a_in;
            sh_b  <= sub ? ~b_in : b_in;
            carry <= sub;
            cnt   <= '0;
            sh_r  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= cell_c;
          sh_r  <= res_next;
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            // On the MSB edge the carry flop still holds the carry into the
            // MSB, so it serves directly as cin_msb for the overflow flag.
            state <= DONE;
            sum   <= res_next;
            cout  <= cell_c;
            ovf   <= carry ^ cell_c;
            zero  <= (res_next == '0);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed, table-driven bench for serial_add_ctrl at WIDTH = 8, plus
//   hand-written sequences for mid-run start, back-to-back start and
//   asynchronous reset during RUN.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int total;
  int bad;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one op at a negedge; E0 is the next posedge. Returns after the
  // done cycle has been sampled. Checks latency, busy length, that sum holds
  // the previous result throughout RUN, and the single-cycle done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] prev_sum, input string tag);
    int cyc;
    int busy_cnt;
    int hold_err;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    hold_err = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      if (sum !== prev_sum) hold_err++;
      @(negedge clk);
      cyc++;
    end
    if (busy) busy_cnt++;
    check({tag, " latency"}, cyc, 8);
    check({tag, " busy_cycles"}, busy_cnt, 9);
    check({tag, " hold_errs"}, hold_err, 0);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, " done_pulse_end"}, {31'd0, done}, 0);
    check({tag, " idle_busy"}, {31'd0, busy}, 0);
  endtask

  logic [W-1:0] last_sum;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a_in  = '0;
    b_in  = '0;

    //            a      b      sub   sum    cout  ovf   zero
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};

    #1;
    check("rst busy", {31'd0, busy}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst sum",  {24'd0, sum}, 0);
    check("rst cout", {31'd0, cout}, 0);
    check("rst ovf",  {31'd0, ovf}, 0);
    check("rst zero", {31'd0, zero}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    last_sum = '0;
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, last_sum, tag);
      check({tag, " sum"},  {24'd0, sum}, {24'd0, vecs[i].e_sum});
      check({tag, " cout"}, {31'd0, cout}, {31'd0, vecs[i].e_cout});
      check({tag, " ovf"},  {31'd0, ovf},  {31'd0, vecs[i].e_ovf});
      check({tag, " zero"}, {31'd0, zero}, {31'd0, vecs[i].e_zero});
      after_done(tag);
      check({tag, " sum_held"}, {24'd0, sum}, {24'd0, vecs[i].e_sum});
      last_sum = vecs[i].e_sum;
    end

    // Hold check: previous sum 0xFF must stay until 0x0F+0x01 completes.
    run_op(8'h0F, 8'h01, 1'b0, last_sum, "hold");
    check("hold sum", {24'd0, sum}, 32'h10);
    after_done("hold");
    run_op(8'h20, 8'h03, 1'b0, 8'h10, "hold2");
    check("hold2 sum", {24'd0, sum}, 32'h23);
    after_done("hold2");

    // Start pulsed mid-run with new operands: must be ignored.
    begin
      int done_cnt;
      @(negedge clk);
      a_in = 8'h12; b_in = 8'h34; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_in = 8'hFF; b_in = 8'hFF; sub = 1'b1;
      done_cnt = 0;
      for (int c = 1; c <= 14; c++) begin
        start = (c == 3 || c == 5);
        @(negedge clk);
        if (done) done_cnt++;
      end
      start = 1'b0;
      check("midstart done_cnt", done_cnt, 1);
      check("midstart sum", {24'd0, sum}, 32'h46);
      check("midstart cout", {31'd0, cout}, 0);
      check("midstart idle", {31'd0, busy}, 0);
    end

    // Back-to-back: start held high, second op accepted right after DONE.
    begin
      int cyc;
      @(negedge clk);
      a_in = 8'h01; b_in = 8'h01; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      a_in = 8'h10;
      cyc = 0;
      while (!done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("b2b first latency", cyc, 8);
      check("b2b first sum", {24'd0, sum}, 32'h02);
      @(negedge clk);
      check("b2b idle gap", {31'd0, busy}, 0);
      @(negedge clk);
      check("b2b reaccept", {31'd0, busy}, 1);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("b2b second latency", cyc, 8);
      check("b2b second sum", {24'd0, sum}, 32'h11);
      after_done("b2b");
    end

    // Asynchronous reset in the middle of RUN.
    begin
      int done_cnt;
      @(negedge clk);
      a_in = 8'h55; b_in = 8'h22; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst busy", {31'd0, busy}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst busy", {31'd0, busy}, 0);
      check("arst done", {31'd0, done}, 0);
      check("arst sum",  {24'd0, sum}, 0);
      check("arst cout", {31'd0, cout}, 0);
      check("arst ovf",  {31'd0, ovf}, 0);
      check("arst zero", {31'd0, zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done || busy) done_cnt++;
      end
      check("arst no_resume", done_cnt, 0);
      run_op(8'h01, 8'h02, 1'b0, 8'h00, "post_rst");
      check("post_rst sum", {24'd0, sum}, 32'h03);
      check("post_rst cout", {31'd0, cout}, 0);
      after_done("post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
